// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared encodings and reload patterns for the LED sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    // Display mode, advanced by the mode key in this order
    typedef enum logic [1:0] {
        MODE_LEFT     = 2'd0,
        MODE_RIGHT    = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;

    // Ping-pong travel direction
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Internal pattern uses 1 = LED lit
    localparam logic [3:0] RELOAD_LEFT     = 4'b0001;
    localparam logic [3:0] RELOAD_RIGHT    = 4'b1000;
    localparam logic [3:0] RELOAD_PINGPONG = 4'b0001;
    localparam logic [3:0] RELOAD_BLINK    = 4'b1111;

    // Ping-pong turnaround points
    localparam logic [3:0] PAT_END_LO      = 4'b0001;
    localparam logic [3:0] PAT_END_HI      = 4'b1000;

    // Board LEDs light when the pin is driven low
    localparam logic       LED_ON_LEVEL    = 1'b0;

    // Pattern loaded when a mode is entered or a corrupt pattern is found
    function automatic logic [3:0] reload_pattern(input mode_e m);
        logic [3:0] p;
        case (m)
            MODE_LEFT:     p = RELOAD_LEFT;
            MODE_RIGHT:    p = RELOAD_RIGHT;
            MODE_PINGPONG: p = RELOAD_PINGPONG;
            MODE_BLINK:    p = RELOAD_BLINK;
            default:       p = RELOAD_LEFT;
        endcase
        return p;
    endfunction

    // True when the pattern can legitimately occur in the given mode
    function automatic logic pattern_legal(input mode_e m, input logic [3:0] p);
        logic ok;
        if (m == MODE_BLINK) begin
            ok = (p == 4'b1111) || (p == 4'b0000);
        end else begin
            ok = $onehot(p);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : led_step_timer
//  Description : Speed register, pausable step counter and one-cycle step
//                pulse. The step limit is the base limit shifted right by the
//                speed setting, so each speed halves the step period.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_step_timer
    import led_ctrl_pkg::*;
#(
    parameter int unsigned          CNT_W   = 25,
    parameter logic [CNT_W-1:0]     CNT_MAX = 25'd24_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clr_i,        // mode change: restart the period
    input  logic        key_speed_i,
    input  logic        key_pause_i,
    output logic [1:0]  speed_o,
    output logic        paused_o,
    output logic        step_o
);

    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] w_lim;
    logic             w_at_lim;

    assign w_lim    = CNT_MAX >> speed_q;
    // >= rather than == so a corrupted count above the limit recovers at once
    assign w_at_lim = (cnt_q >= w_lim);

    // Next-state: key pulses first; a speed or mode pulse suppresses the wrap
    always_comb begin
        speed_d  = speed_q;
        paused_d = paused_q;
        cnt_d    = cnt_q;
        step_o   = 1'b0;

        if (key_speed_i) begin
            speed_d = speed_q + 2'd1;
        end
        if (key_pause_i) begin
            paused_d = ~paused_q;
        end

        if (clr_i || key_speed_i) begin
            cnt_d = '0;
        end else if (!paused_q) begin
            if (w_at_lim) begin
                cnt_d  = '0;
                step_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            speed_q  <= speed_d;
            paused_q <= paused_d;
            cnt_q    <= cnt_d;
        end
    end

    assign speed_o  = speed_q;
    assign paused_o = paused_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Four-LED pattern sequencer with key-selected mode, speed and
//                pause. Drives the active-low LED pins directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned          CNT_W   = 25,
    parameter logic [CNT_W-1:0]     CNT_MAX = 25'd24_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_mode,
    input  logic        key_speed,
    input  logic        key_pause,
    output logic [3:0]  led_out,
    output logic [1:0]  mode,
    output logic [1:0]  speed,
    output logic        paused
);

    mode_e      mode_q, mode_d;
    dir_e       dir_q, dir_d;
    logic [3:0] pattern_q, pattern_d;
    logic       w_step;

    led_step_timer #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_step_timer (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .clr_i       (key_mode),
        .key_speed_i (key_speed),
        .key_pause_i (key_pause),
        .speed_o     (speed),
        .paused_o    (paused),
        .step_o      (w_step)
    );

    // Mode FSM and pattern next-state; a mode pulse wins over any step
    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        pattern_d = pattern_q;

        if (key_mode) begin
            mode_d    = mode_e'(mode_q + 2'd1);
            pattern_d = reload_pattern(mode_e'(mode_q + 2'd1));
            dir_d     = DIR_UP;
        end else if (w_step) begin
            if (!pattern_legal(mode_q, pattern_q)) begin
                pattern_d = reload_pattern(mode_q);
                dir_d     = DIR_UP;
            end else begin
                case (mode_q)
                    MODE_LEFT:  pattern_d = {pattern_q[2:0], pattern_q[3]};
                    MODE_RIGHT: pattern_d = {pattern_q[0], pattern_q[3:1]};
                    MODE_PINGPONG: begin
                        // Turn around on the end LED so it shows for one period only
                        if (pattern_q == PAT_END_HI) begin
                            dir_d     = DIR_DOWN;
                            pattern_d = pattern_q >> 1;
                        end else if (pattern_q == PAT_END_LO) begin
                            dir_d     = DIR_UP;
                            pattern_d = pattern_q << 1;
                        end else if (dir_q == DIR_UP) begin
                            pattern_d = pattern_q << 1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                    MODE_BLINK: pattern_d = ~pattern_q;
                    default:    pattern_d = reload_pattern(mode_q);
                endcase
            end
        end
    end

    // Mode, direction and pattern registers with asynchronous reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= MODE_LEFT;
            dir_q     <= DIR_UP;
            pattern_q <= RELOAD_LEFT;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            pattern_q <= pattern_d;
        end
    end

    // Invert only when the LEDs are lit by a low level
    assign led_out = pattern_q ^ {4{~LED_ON_LEVEL}};
    assign mode    = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Directed and random stimulus for led_pattern_ctrl, compared
//                each cycle against a sequence-index reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int unsigned      CNT_W   = 25;
    localparam logic [CNT_W-1:0] CNT_MAX = 25'd7;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_mode  = 1'b0;
    logic       key_speed = 1'b0;
    logic       key_pause = 1'b0;
    logic [3:0] led_out;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       paused;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the mode's display sequence
    int m_mode, m_speed, m_paused, m_elapsed, m_pos;

    logic [3:0] pp_seq [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                               4'b1011, 4'b1101, 4'b1110, 4'b1101};

    led_pattern_ctrl #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .key_pause (key_pause),
        .led_out   (led_out),
        .mode      (mode),
        .speed     (speed),
        .paused    (paused)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int seq_len(input int md);
        case (md)
            2:       return 6;
            3:       return 2;
            default: return 4;
        endcase
    endfunction

    // Lit LEDs (1 = on) at a given position of each mode's sequence
    function automatic logic [3:0] exp_pattern(input int md, input int pos);
        logic [3:0] one;
        one = 4'b0001;
        case (md)
            0:       return one << pos;
            1:       return 4'b1000 >> pos;
            2:       return (pos <= 3) ? (one << pos) : (one << (6 - pos));
            default: return (pos == 0) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_paused = 0; m_elapsed = 0; m_pos = 0;
    endtask

    task automatic model_step(input logic km, input logic ks, input logic kp);
        int period;
        period = (int'(CNT_MAX) >> m_speed) + 1;
        if (km || ks) begin
            if (km) begin
                m_mode = (m_mode + 1) % 4;
                m_pos  = 0;
            end
            if (ks) m_speed = (m_speed + 1) % 4;
            m_elapsed = 0;
        end else if (m_paused == 0) begin
            if (m_elapsed + 1 == period) begin
                m_elapsed = 0;
                m_pos     = (m_pos + 1) % seq_len(m_mode);
            end else begin
                m_elapsed++;
            end
        end
        if (kp) m_paused = (m_paused == 0) ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("led_out", led_out, ~exp_pattern(m_mode, m_pos));
        check("mode",    {2'b00, mode},   4'(m_mode));
        check("speed",   {2'b00, speed},  4'(m_speed));
        check("paused",  {3'b000, paused}, 4'(m_paused));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led"},    led_out, 4'b1110);
        check({tag, "_mode"},   {2'b00, mode},   4'd0);
        check({tag, "_speed"},  {2'b00, speed},  4'd0);
        check({tag, "_paused"}, {3'b000, paused}, 4'd0);
    endtask

    // One clock: drive keys, let the edge happen, advance model, compare
    task automatic tick(input logic km, input logic ks, input logic kp);
        key_mode  = km;
        key_speed = ks;
        key_pause = kp;
        @(posedge sys_clk);
        model_step(km, ks, kp);
        #1;
        key_mode  = 1'b0;
        key_speed = 1'b0;
        key_pause = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Free-running left walk at speed 0
        idle(40);

        // Speed cycling through all four settings
        for (int s = 0; s < 4; s++) begin
            tick(1'b0, 1'b1, 1'b0);
            idle(18);
        end

        // Ping-pong at full speed
        tick(1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("pp_0", led_out, pp_seq[0]);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check("pp_seq", led_out, pp_seq[i]);
        end

        // Pause mid-period and resume
        tick(1'b0, 1'b1, 1'b0);
        idle(3);
        tick(1'b0, 1'b0, 1'b1);
        check("pause_flag", {3'b000, paused}, 4'd1);
        idle(20);
        tick(1'b0, 1'b0, 1'b1);
        idle(6);

        // Mode and speed together on a wrap cycle
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        idle(7);
        tick(1'b1, 1'b1, 1'b0);
        check("sim_mode",  {2'b00, mode},  4'd1);
        check("sim_speed", {2'b00, speed}, 4'd1);
        check("sim_led",   led_out, 4'b0111);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check("sim_hold", led_out, 4'b0111);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("sim_step", led_out, 4'b1011);

        // Asynchronous reset while blinking and paused
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        idle(5);
        tick(1'b0, 1'b0, 1'b1);
        idle(2);
        check("pre_rst_paused", {3'b000, paused}, 4'd1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(12);

        // Random key activity
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 17) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the 4-LED board bank that adds runtime control on top of the fixed water-flow pattern. It takes debounced single-cycle key pulses and uses them to select among four display patterns and four step speeds, and to pause or resume stepping. It sits between the key debouncers and the LED pins and drives the active-low `led_out` bus directly.

## Interface
Parameters:
- `CNT_MAX`, default `25'd24_999_999`: base step limit. Step period at speed 0 is `CNT_MAX+1` cycles, 0.5 s at 50 MHz.
- `CNT_W`, default `25`: width of the step counter. Must hold `CNT_MAX`.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `key_mode` in 1: one-cycle pulse; advances mode 0→1→2→3→0.
- `key_speed` in 1: one-cycle pulse; advances speed 0→1→2→3→0.
- `key_pause` in 1: one-cycle pulse; toggles `paused`.
- `led_out` out 4: LED drive, active-low, equal to `~pattern`.
- `mode` out 2: current mode.
- `speed` out 2: current speed.
- `paused` out 1: 1 while stepping is frozen.

## Operation
- Step limit `lim = CNT_MAX >> speed`. Counter `cnt` counts 0..`lim`.
- Each unpaused cycle: if `cnt == lim`, then `cnt <= 0` and the pattern steps on the same edge. Otherwise `cnt <= cnt + 1`.
- Paused: `cnt` and the pattern hold.
- Modes and their reload pattern (internal `pattern`, 1 = LED on):
  - 0 LEFT: reload `0001`. Sequence 0001→0010→0100→1000→0001.
  - 1 RIGHT: reload `1000`. Sequence 1000→0100→0010→0001→1000.
  - 2 PINGPONG: reload `0001`, direction reg `dir` = up.
    - Shifts left while up, right while down.
    - At `1000`, `dir` flips to down and the pattern shifts right in the same step, giving `0100`. At `0001`, `dir` flips to up and the next pattern is `0010`.
    - End patterns are shown for exactly one period.
  - 3 BLINK: reload `1111`. Toggles `1111`↔`0000` each step.
- `key_mode`: mode increments, the pattern loads the new mode's reload value, `cnt <= 0`, `dir <= up`. `paused` is unchanged, so a mode change while paused shows the reload pattern frozen.
- `key_speed`: speed increments, `cnt <= 0`, pattern held.
- `key_pause`: `paused` toggles. `cnt` is not cleared, so resume continues the partial period.
- Simultaneous pulses: all pulses present in a cycle take effect on the same edge. A mode or speed pulse overrides the counter wrap and step in that cycle: `cnt <= 0` and no step. The pattern is the reload value if `key_mode` is present, otherwise held.
- Illegal pattern values (e.g. after an SEU) reload the current mode's reload value at the next step.

## Timing
- Reset values: `mode`=0, `speed`=0, `paused`=0, `dir`=up, `cnt`=0, `pattern`=`0001`, `led_out`=`4'b1110`.
- All outputs are registered or derived with a single inverter. Key pulse at edge N is visible on outputs after edge N.
- First step after reset or after any counter clear occurs `lim+1` cycles later.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Stepping restarts from zero after deassertion.

## Structure
- Shared package or header `led_ctrl_pkg` holds:
  - mode encodings `MODE_LEFT`/`MODE_RIGHT`/`MODE_PINGPONG`/`MODE_BLINK`;
  - reload pattern constants;
  - `LED_ON_LEVEL`, active-low.
- Sub-module `led_step_timer` holds the speed register, `cnt`, the `lim` shift and the pause gating, and outputs a one-cycle `step` pulse.
- `led_pattern_ctrl` holds the mode FSM, the `dir` register and the pattern register.

## Test plan
All scenarios use `CNT_MAX=7`, giving periods of 8, 4, 2 and 1 cycles at speeds 0–3.
1. Reset release, no keys → `led_out` is 1110 for 8 cycles, then 1101, 1011, 0111, 1110, each held 8 cycles.
2. One `key_speed` pulse, then 3 more → period becomes 4, then 2, then 1 cycle; 4th pulse returns to 8. Pattern never jumps at the speed change.
3. Mode 2 at speed 3 → `led_out` sequence 1110,1101,1011,0111,1011,1101,1110,1101.
4. `key_pause` mid-period (after `cnt`=3), hold 20 cycles, pulse again → LEDs frozen; next step occurs exactly 4 cycles after resume.
5. `key_mode` and `key_speed` in the same cycle as a `cnt==lim` wrap → mode=1, speed=1, `led_out`=0111, next step 4 cycles later to 1011.
6. Assert `sys_rst_n` low mid-blink (mode 3, speed 2, paused) → all outputs return to reset values asynchronously.
